// File: rtl/demux_1tn_hs_pkg.sv
// Shared types and constants for the 1-to-N handshake demultiplexer.
// Holding-register state encoding and drop-counter width.
package demux_1tn_hs_pkg;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/demux_chan_stage.sv
// One output channel: a data holding register plus its EMPTY/FULL flag.
// A load always wins; a drain without a load empties the channel and zeroes q.
module demux_chan_stage
  import demux_1tn_hs_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [n-1:0] d,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         free,
  output logic [n-1:0] q
);

  ch_state_e state;

  assign out_valid = (state == CH_FULL);
  assign free      = !out_valid || out_ready;

  // NOTE: the data register is reset too, because an empty channel must drive zeros.
  // NOTE: sequential state uses non-blocking assignments only, so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CH_EMPTY;
      q     <= '0;
    end else if (load) begin
      state <= CH_FULL;
      q     <= d;
    end else if (out_valid && out_ready) begin
      state <= CH_EMPTY;
      q     <= '0;
    end
  end

endmodule

// File: rtl/demux_1tn_hs.sv
// Registered 1-to-N demultiplexer with valid/ready on the input and every output.
// Routes each accepted word to one channel (or all, in broadcast); bad indices are dropped and counted.
module demux_1tn_hs
  import demux_1tn_hs_pkg::*;
#(
  parameter int n     = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  bcast,
  input  logic [n-1:0]          d_in,
  output logic [N_OUT-1:0]      out_valid,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [N_OUT*n-1:0]    d_out,
  output logic                  drop,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // One extra bit so N_OUT itself is representable when N_OUT == 2**SEL_W.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] load;
  logic             in_range;
  logic             accept;
  logic             drop_now;

  assign in_range = ({1'b0, sel} < N_OUT_L);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k] = ({1'b0, sel} == (SEL_W+1)'(k));
    end
  end

  // Ready depends only on sel/bcast and channel state, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    if (bcast)         in_ready = &free;
    else if (in_range) in_ready = |(hit & free);
  end

  assign accept   = in_valid && in_ready;
  assign drop_now = accept && !bcast && !in_range;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = accept && (bcast || hit[k]);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    demux_chan_stage #(.n(n)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .d         (d_in),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .free      (free[k]),
      .q         (d_out[k*n +: n])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop <= drop_now;
      if (drop_now && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
